// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding select, ID-stage stalls, branch flush, memory-latency freeze.
// Optional performance counters are enabled by defining HZ_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int RA_W    = 4,
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic             id_br_reg,
  input  logic             id_br_flag,
  input  logic             br_taken,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_wr,
  input  logic             ex_load,
  input  logic             ex_setflags,
  input  logic [RA_W-1:0]  mem_rd,
  input  logic             mem_wr,
  input  logic             mem_load,
  input  logic             mem_req,
  input  logic             mem_store,
  input  logic [RA_W-1:0]  mem_st_rt,
  input  logic [RA_W-1:0]  wb_rd,
  input  logic             wb_wr,
  input  logic             wb_load,
  input  logic [RA_W-1:0]  ex_rs,
  input  logic [RA_W-1:0]  ex_rt,
  output logic             stall_front,
  output logic             bubble_ex,
  output logic             stall_back,
  output logic             bubble_wb,
  output logic             flush_ifid,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             fwd_st,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam bit         MULTI_CYC = (MEM_LAT > 1);
  localparam logic [3:0] LAT_LOAD  = MULTI_CYC ? 4'(MEM_LAT - 2) : 4'd0;

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic       w_mem_busy;
  logic       w_ld_use;
  logic       w_br_reg_hz;
  logic       w_br_flag_hz;
  logic       w_id_hz;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  // A match against register 0 never counts: r0 is hardwired zero.
  function automatic logic reg_match(input logic [RA_W-1:0] r, input logic [RA_W-1:0] rd);
    return (r == rd) && (rd != '0);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= 4'd0;
    else if (r_state == S_IDLE && mem_req && MULTI_CYC)
      r_cnt <= LAT_LOAD;
    else if (r_state == S_BUSY && r_cnt != 4'd0)
      r_cnt <= r_cnt - 4'd1;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (mem_req && MULTI_CYC) w_next = S_BUSY;
      S_BUSY: if (r_cnt == 4'd0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // The last BUSY cycle releases the freeze so the access totals MEM_LAT cycles.
  always_comb begin
    w_mem_busy = 1'b0;
    case (r_state)
      S_IDLE: w_mem_busy = mem_req && MULTI_CYC;
      S_BUSY: w_mem_busy = (r_cnt != 4'd0);
      default: w_mem_busy = 1'b0;
    endcase
  end

  always_comb begin
    w_fwd_a = 2'b00;
    if (mem_wr && !mem_load && reg_match(ex_rs, mem_rd)) w_fwd_a = 2'b01;
    else if (wb_wr && reg_match(ex_rs, wb_rd))           w_fwd_a = 2'b10;
    w_fwd_b = 2'b00;
    if (mem_wr && !mem_load && reg_match(ex_rt, mem_rd)) w_fwd_b = 2'b01;
    else if (wb_wr && reg_match(ex_rt, wb_rd))           w_fwd_b = 2'b10;
  end

  // Register branches read rs in ID, so the producer must have reached WB.
  assign w_ld_use     = ex_load && ex_wr &&
                        ((id_rs_used && reg_match(id_rs, ex_rd)) ||
                         (id_rt_used && reg_match(id_rt, ex_rd)));
  assign w_br_reg_hz  = id_br_reg && ((ex_wr && reg_match(id_rs, ex_rd)) ||
                                      (mem_wr && reg_match(id_rs, mem_rd)));
  assign w_br_flag_hz = id_br_flag && ex_setflags;
  assign w_id_hz      = w_ld_use || w_br_reg_hz || w_br_flag_hz;

  assign stall_back  = !rst && w_mem_busy;
  assign bubble_wb   = !rst && w_mem_busy;
  assign stall_front = !rst && (w_mem_busy || w_id_hz);
  assign bubble_ex   = !rst && w_id_hz && !w_mem_busy;
  assign flush_ifid  = !rst && br_taken && !w_id_hz && !w_mem_busy;
  assign fwd_a       = rst ? 2'b00 : w_fwd_a;
  assign fwd_b       = rst ? 2'b00 : w_fwd_b;
  assign fwd_st      = !rst && mem_store && wb_load && wb_wr && reg_match(mem_st_rt, wb_rd);

`ifdef HZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (stall_front && r_stall_cycles != '1) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (flush_ifid && r_flush_count != '1)   r_flush_count  <= r_flush_count + CNT_W'(1);
    end
  end

  assign stall_cycles = rst ? '0 : r_stall_cycles;
  assign flush_count  = rst ? '0 : r_flush_count;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl with MEM_LAT=4.
// Counter expectations follow whether HZ_PERF_CNT_EN is defined.
module tb_hazard_ctrl;

  localparam int RA_W = 4;
  localparam int CNT_W = 16;
`ifdef HZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [RA_W-1:0] id_rs, id_rt, ex_rd, mem_rd, mem_st_rt, wb_rd, ex_rs, ex_rt;
  logic id_rs_used, id_rt_used, id_br_reg, id_br_flag, br_taken;
  logic ex_wr, ex_load, ex_setflags;
  logic mem_wr, mem_load, mem_req, mem_store;
  logic wb_wr, wb_load;
  logic stall_front, bubble_ex, stall_back, bubble_wb, flush_ifid, fwd_st;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.RA_W(RA_W), .MEM_LAT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_br_reg(id_br_reg), .id_br_flag(id_br_flag), .br_taken(br_taken),
    .ex_rd(ex_rd), .ex_wr(ex_wr), .ex_load(ex_load), .ex_setflags(ex_setflags),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_load(mem_load), .mem_req(mem_req),
    .mem_store(mem_store), .mem_st_rt(mem_st_rt),
    .wb_rd(wb_rd), .wb_wr(wb_wr), .wb_load(wb_load),
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .stall_front(stall_front), .bubble_ex(bubble_ex), .stall_back(stall_back),
    .bubble_wb(bubble_wb), .flush_ifid(flush_ifid),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_st(fwd_st),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rd = '0; mem_rd = '0; mem_st_rt = '0; wb_rd = '0;
    ex_rs = '0; ex_rt = '0;
    id_rs_used = 0; id_rt_used = 0; id_br_reg = 0; id_br_flag = 0; br_taken = 0;
    ex_wr = 0; ex_load = 0; ex_setflags = 0;
    mem_wr = 0; mem_load = 0; mem_req = 0; mem_store = 0;
    wb_wr = 0; wb_load = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs settle before checks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    ex_load = 1; ex_wr = 1; ex_rd = 4'd3; id_rs = 4'd3; id_rs_used = 1; mem_req = 1;
    tick();
    settle();
    checks++;
    if (stall_front !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall_front got %b exp 0", stall_front); end
    checks++;
    if (stall_back !== 1'b0) begin fails++; $display("[TB] FAIL reset_stall_back got %b exp 0", stall_back); end
    checks++;
    if (stall_cycles !== '0 || flush_count !== '0) begin
      fails++; $display("[TB] FAIL reset_counters got %0d/%0d exp 0/0", stall_cycles, flush_count);
    end
    clear_inputs();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_load = 1; ex_wr = 1; ex_rd = 4'd3; id_rs = 4'd3; id_rs_used = 1;
    settle();
    checks++;
    if (stall_front !== 1'b1 || bubble_ex !== 1'b1) begin
      fails++; $display("[TB] FAIL load_use_hit got %b%b exp 11", stall_front, bubble_ex);
    end
    tick();
    ex_load = 0; ex_wr = 0; ex_rd = '0; mem_load = 1; mem_wr = 1; mem_rd = 4'd3;
    settle();
    checks++;
    if (stall_front !== 1'b0 || bubble_ex !== 1'b0) begin
      fails++; $display("[TB] FAIL load_use_next got %b%b exp 00", stall_front, bubble_ex);
    end
    tick();
    clear_inputs();
    ex_load = 1; ex_wr = 1; ex_rd = 4'd9; id_rt = 4'd9; id_rt_used = 1; id_rs = 4'd9;
    settle();
    checks++;
    if (bubble_ex !== 1'b1) begin fails++; $display("[TB] FAIL load_use_rt got %b exp 1", bubble_ex); end
    id_rt_used = 0;
    ex_rd = '0; id_rt = '0; id_rs = '0; id_rs_used = 1;
    settle();
    checks++;
    if (stall_front !== 1'b0) begin fails++; $display("[TB] FAIL load_use_r0 got %b exp 0", stall_front); end
    tick();
    clear_inputs();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    mem_wr = 1; mem_rd = 4'd5; wb_wr = 1; wb_rd = 4'd5; ex_rs = 4'd5;
    settle();
    checks++;
    if (fwd_a !== 2'b01) begin fails++; $display("[TB] FAIL fwd_a_mem got %b exp 01", fwd_a); end
    mem_load = 1;
    settle();
    checks++;
    if (fwd_a !== 2'b10) begin fails++; $display("[TB] FAIL fwd_a_load_wb got %b exp 10", fwd_a); end
    mem_load = 0; mem_rd = '0; wb_rd = '0; ex_rs = '0;
    settle();
    checks++;
    if (fwd_a !== 2'b00) begin fails++; $display("[TB] FAIL fwd_a_r0 got %b exp 00", fwd_a); end
    mem_rd = 4'd5; ex_rs = 4'd5; wb_rd = 4'd7; ex_rt = 4'd7;
    settle();
    checks++;
    if (fwd_a !== 2'b01 || fwd_b !== 2'b10) begin
      fails++; $display("[TB] FAIL fwd_ab_split got %b/%b exp 01/10", fwd_a, fwd_b);
    end
    mem_store = 1; mem_st_rt = 4'd6; wb_load = 1; wb_rd = 4'd6;
    settle();
    checks++;
    if (fwd_st !== 1'b1) begin fails++; $display("[TB] FAIL fwd_st_hit got %b exp 1", fwd_st); end
    wb_load = 0;
    settle();
    checks++;
    if (fwd_st !== 1'b0) begin fails++; $display("[TB] FAIL fwd_st_noload got %b exp 0", fwd_st); end
    clear_inputs();
  endtask

  task automatic test_reg_branch();
    do_reset();
    id_br_reg = 1; id_rs = 4'd2; br_taken = 1; ex_wr = 1; ex_rd = 4'd2;
    settle();
    checks++;
    if (stall_front !== 1'b1 || flush_ifid !== 1'b0) begin
      fails++; $display("[TB] FAIL br_reg_ex got %b%b exp 10", stall_front, flush_ifid);
    end
    tick();
    ex_wr = 0; ex_rd = '0; mem_wr = 1; mem_rd = 4'd2;
    settle();
    checks++;
    if (stall_front !== 1'b1) begin fails++; $display("[TB] FAIL br_reg_mem got %b exp 1", stall_front); end
    tick();
    mem_wr = 0; mem_rd = '0; wb_wr = 1; wb_rd = 4'd2;
    settle();
    checks++;
    if (stall_front !== 1'b0 || flush_ifid !== 1'b1) begin
      fails++; $display("[TB] FAIL br_reg_release got %b%b exp 01", stall_front, flush_ifid);
    end
    tick();
    clear_inputs();
    settle();
    checks++;
    if (flush_count !== (PERF ? 16'd1 : 16'd0) || stall_cycles !== (PERF ? 16'd2 : 16'd0)) begin
      fails++; $display("[TB] FAIL br_reg_counters got %0d/%0d exp %0d/%0d",
                        flush_count, stall_cycles, PERF ? 1 : 0, PERF ? 2 : 0);
    end
  endtask

  task automatic test_flag_branch();
    clear_inputs();
    id_br_flag = 1; ex_setflags = 1; br_taken = 1;
    settle();
    checks++;
    if (stall_front !== 1'b1 || bubble_ex !== 1'b1 || flush_ifid !== 1'b0) begin
      fails++; $display("[TB] FAIL br_flag_hit got %b%b%b exp 110", stall_front, bubble_ex, flush_ifid);
    end
    tick();
    ex_setflags = 0;
    settle();
    checks++;
    if (stall_front !== 1'b0 || flush_ifid !== 1'b1) begin
      fails++; $display("[TB] FAIL br_flag_release got %b%b exp 01", stall_front, flush_ifid);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_mem_latency();
    logic exp_busy [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    clear_inputs();
    mem_req = 1;
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++;
      if (stall_back !== exp_busy[c] || bubble_wb !== exp_busy[c]) begin
        fails++; $display("[TB] FAIL mem_lat_cycle%0d got %b%b exp %b%b",
                          c, stall_back, bubble_wb, exp_busy[c], exp_busy[c]);
      end
      tick();
      mem_req = 0;
    end
  endtask

  task automatic test_mem_and_hazard();
    logic exp_bub [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    mem_req = 1; ex_load = 1; ex_wr = 1; ex_rd = 4'd3; id_rs = 4'd3; id_rs_used = 1;
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++;
      if (stall_front !== 1'b1 || bubble_ex !== exp_bub[c]) begin
        fails++; $display("[TB] FAIL mem_hz_cycle%0d got %b%b exp 1%b", c, stall_front, bubble_ex, exp_bub[c]);
      end
      tick();
    end
    clear_inputs();
    settle();
    checks++;
    if (stall_cycles !== (PERF ? 16'd4 : 16'd0) || stall_front !== 1'b0) begin
      fails++; $display("[TB] FAIL mem_hz_stall_cycles got %0d/%b exp %0d/0",
                        stall_cycles, stall_front, PERF ? 4 : 0);
    end
    tick();
  endtask

  task automatic test_reset_mid_busy();
    clear_inputs();
    mem_req = 1;
    tick();
    mem_req = 0;
    settle();
    checks++;
    if (stall_back !== 1'b1) begin fails++; $display("[TB] FAIL mid_busy_first got %b exp 1", stall_back); end
    tick();
    rst = 1'b1;
    settle();
    checks++;
    if (stall_back !== 1'b0) begin fails++; $display("[TB] FAIL mid_busy_in_rst got %b exp 0", stall_back); end
    tick();
    rst = 1'b0;
    settle();
    checks++;
    if (stall_back !== 1'b0 || stall_cycles !== '0 || flush_count !== '0) begin
      fails++; $display("[TB] FAIL mid_busy_after got %b %0d %0d exp 0 0 0", stall_back, stall_cycles, flush_count);
    end
    mem_req = 1;
    settle();
    checks++;
    if (stall_back !== 1'b1) begin fails++; $display("[TB] FAIL mid_busy_idle_restart got %b exp 1", stall_back); end
    tick();
    mem_req = 0;
    repeat (3) tick();
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_load_use();
    test_forwarding();
    test_reg_branch();
    test_flag_branch();
    test_mem_latency();
    test_mem_and_hazard();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
